// File: rtl/pc_pkg.sv
// Shared types and helpers for the PC sequencer and its return-address stack.
// Latency: none; this package holds only types, constants and pure functions.
// Backpressure: none.
package pc_pkg;

    // The encoding is ordered so that a numerically larger value means higher priority.
    typedef enum logic [2:0] {
        SRC_SEQ    = 3'd0,
        SRC_BRANCH = 3'd1,
        SRC_JUMP   = 3'd2,
        SRC_RET    = 3'd3,
        SRC_TRAP   = 3'd4
    } redirect_src_t;

    localparam int RAS_DEPTH_DEFAULT = 4;
    localparam int RAS_PTR_W         = $clog2(RAS_DEPTH_DEFAULT);

    // Widest address this helper handles; callers zero-extend and truncate around it.
    localparam int ADDR_MAX_W = 64;

    // Clears the log2(instr_bytes) low bits so every fetch address is instruction aligned.
    function automatic logic [ADDR_MAX_W-1:0] align_target(
        input logic [ADDR_MAX_W-1:0] addr,
        input int unsigned           instr_bytes
    );
        logic [ADDR_MAX_W-1:0] mask;
        mask = ~(ADDR_MAX_W'(instr_bytes) - ADDR_MAX_W'(1));
        return addr & mask;
    endfunction

endpackage

// File: rtl/pc_sequencer_ras.sv
// Circular return-address stack: push stores a return address, pop discards the top entry.
// Latency: top/empty/full are combinational from state; a push or pop takes effect at the next edge.
// Backpressure: none; a push when full overwrites the oldest entry, and a pop when empty is ignored.
module ras_stack
    import pc_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic                         push,
    input  logic                         pop,
    input  logic [XLEN-1:0]              push_data,
    output logic [XLEN-1:0]              top,
    output logic                         empty,
    output logic                         full,
    output logic [$clog2(RAS_DEPTH)-1:0] ptr,
    output logic [$clog2(RAS_DEPTH):0]   count
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [XLEN-1:0]  mem [RAS_DEPTH];
    logic [PTR_W-1:0] top_idx;

    // ptr is the next slot to write; the most recent entry sits just below it.
    assign top_idx = ptr - PTR_W'(1);
    assign top     = mem[top_idx];
    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(RAS_DEPTH));

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            ptr   <= '0;
            count <= '0;
        end else if (pop) begin
            if (!empty) begin
                ptr   <= top_idx;
                count <= count - CNT_W'(1);
            end
        end else if (push) begin
            // ptr wraps naturally because RAS_DEPTH is a power of two.
            ptr <= ptr + PTR_W'(1);
            if (!full) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read while count says they are valid.
    always_ff @(posedge CLK) begin
        if (push && !pop) begin
            mem[ptr] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: priority-selects the next PC from trap/return/jump/branch/sequential sources.
// Latency: one cycle from request to PC; PC_NEXT_SEQ is combinational from PC only.
// Backpressure: BUSYWAIT or I_BUSYWAIT holds PC; the highest-priority redirect seen meanwhile is replayed on release.
// Ports: CLK/RESET_N; stall inputs BUSYWAIT, I_BUSYWAIT; requests TRAP, RET, JUMP(+CALL, JUMP_TARGET),
//        BRANCH_TAKEN(+BRANCH_TARGET); outputs PC, PC_NEXT_SEQ, REDIRECT_PENDING and RAS status flags.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'('h100),
    parameter int              INSTR_BYTES  = 4,
    parameter int              RAS_DEPTH    = 4
) (
    input  logic            CLK,
    input  logic            RESET_N,
    input  logic            BUSYWAIT,
    input  logic            I_BUSYWAIT,
    input  logic            BRANCH_TAKEN,
    input  logic [XLEN-1:0] BRANCH_TARGET,
    input  logic            JUMP,
    input  logic [XLEN-1:0] JUMP_TARGET,
    input  logic            CALL,
    input  logic            RET,
    input  logic            TRAP,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_NEXT_SEQ,
    output logic            REDIRECT_PENDING,
    output logic            RAS_EMPTY,
    output logic            RAS_UNDERFLOW,
    output logic            RAS_OVERFLOW
);
    localparam int PTR_W = $clog2(RAS_DEPTH);

    function automatic logic [XLEN-1:0] align(input logic [XLEN-1:0] addr);
        return XLEN'(align_target(ADDR_MAX_W'(addr), INSTR_BYTES));
    endfunction

    logic            stall;
    redirect_src_t   req_src;
    logic [XLEN-1:0] req_raw;
    logic [XLEN-1:0] req_target;
    logic            req_call;
    logic            capture;

    logic            pend_vld;
    redirect_src_t   pend_src;
    logic [XLEN-1:0] pend_target;
    logic            pend_call;
    logic            pend_ret;

    logic [XLEN-1:0] commit_target;
    logic            commit_call;
    logic            commit_ret;

    logic            ras_push;
    logic            ras_pop;
    logic [XLEN-1:0] ras_top;
    logic            ras_empty;
    logic            ras_full;
    logic [PTR_W-1:0] ras_ptr;
    logic [PTR_W:0]   ras_count;
    logic            unused_ras;

    assign stall       = BUSYWAIT | I_BUSYWAIT;
    assign PC_NEXT_SEQ = PC + XLEN'(INSTR_BYTES);

    always_comb begin
        req_src  = SRC_SEQ;
        req_raw  = PC_NEXT_SEQ;
        req_call = 1'b0;
        if (TRAP) begin
            req_src = SRC_TRAP;
            req_raw = TRAP_VECTOR;
        end else if (RET) begin
            req_src = SRC_RET;
            // An empty stack has nothing to predict, so the return falls through.
            req_raw = ras_empty ? PC_NEXT_SEQ : ras_top;
        end else if (JUMP) begin
            req_src  = SRC_JUMP;
            req_raw  = JUMP_TARGET;
            req_call = CALL;
        end else if (BRANCH_TAKEN) begin
            req_src = SRC_BRANCH;
            req_raw = BRANCH_TARGET;
        end
        req_target = align(req_raw);
    end

    // During a stall only a strictly higher-priority redirect may replace the captured one.
    assign capture = stall && (req_src != SRC_SEQ) && (!pend_vld || (req_src > pend_src));

    // On the release edge the pending entry wins outright: the held instruction is
    // re-presenting the same request, so taking the live inputs would act on it twice.
    assign commit_target = pend_vld ? pend_target : req_target;
    assign commit_call   = pend_vld ? pend_call   : req_call;
    assign commit_ret    = pend_vld ? pend_ret    : (req_src == SRC_RET);

    // The stack only moves on the edge where PC actually advances.
    assign ras_push = !stall && commit_call;
    assign ras_pop  = !stall && commit_ret;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            PC            <= RESET_VECTOR;
            pend_vld      <= 1'b0;
            pend_src      <= SRC_SEQ;
            pend_target   <= '0;
            pend_call     <= 1'b0;
            pend_ret      <= 1'b0;
            RAS_UNDERFLOW <= 1'b0;
            RAS_OVERFLOW  <= 1'b0;
        end else if (stall) begin
            if (capture) begin
                pend_vld    <= 1'b1;
                pend_src    <= req_src;
                pend_target <= req_target;
                pend_call   <= req_call;
                pend_ret    <= (req_src == SRC_RET);
            end
        end else begin
            PC       <= commit_target;
            pend_vld <= 1'b0;
            pend_src <= SRC_SEQ;
            if (ras_pop && ras_empty) begin
                RAS_UNDERFLOW <= 1'b1;
            end
            if (ras_push && ras_full) begin
                RAS_OVERFLOW <= 1'b1;
            end
        end
    end

    assign REDIRECT_PENDING = pend_vld;
    assign RAS_EMPTY        = ras_empty;

    ras_stack #(
        .XLEN      (XLEN),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (PC_NEXT_SEQ),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full),
        .ptr       (ras_ptr),
        .count     (ras_count)
    );

    // Pointer and occupancy are exported by the stack for observability only.
    assign unused_ras = ^{ras_ptr, ras_count};

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios plus randomized traffic against a queue-based model.
// Latency: model advances on each rising edge; outputs are compared on every falling edge.
// Backpressure: stalls are driven randomly and in directed sequences.
module tb_pc_sequencer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Main instance: 32-bit, reset vector 'h40.
    logic        rst_n = 1'b1;
    logic        busywait, i_busywait, branch_taken, jump, call, ret, trap;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc, pc_next_seq;
    logic        redirect_pending, ras_empty, ras_underflow, ras_overflow;

    // Narrow instance for wrap-around and alignment.
    logic        rst8_n = 1'b1;
    logic        br8;
    logic [7:0]  bt8;
    logic [7:0]  pc8, pc_next_seq8;
    logic        pend8, empty8, uf8, of8;

    int checks = 0;
    int errors = 0;
    bit mdl_on = 1'b0;

    pc_sequencer #(
        .XLEN(32), .RESET_VECTOR(32'h40), .TRAP_VECTOR(32'h100), .INSTR_BYTES(4), .RAS_DEPTH(4)
    ) u_dut (
        .CLK(CLK), .RESET_N(rst_n), .BUSYWAIT(busywait), .I_BUSYWAIT(i_busywait),
        .BRANCH_TAKEN(branch_taken), .BRANCH_TARGET(branch_target),
        .JUMP(jump), .JUMP_TARGET(jump_target), .CALL(call), .RET(ret), .TRAP(trap),
        .PC(pc), .PC_NEXT_SEQ(pc_next_seq), .REDIRECT_PENDING(redirect_pending),
        .RAS_EMPTY(ras_empty), .RAS_UNDERFLOW(ras_underflow), .RAS_OVERFLOW(ras_overflow)
    );

    pc_sequencer #(
        .XLEN(8), .RESET_VECTOR(8'hF8), .TRAP_VECTOR(8'h80), .INSTR_BYTES(4), .RAS_DEPTH(4)
    ) u_dut8 (
        .CLK(CLK), .RESET_N(rst8_n), .BUSYWAIT(1'b0), .I_BUSYWAIT(1'b0),
        .BRANCH_TAKEN(br8), .BRANCH_TARGET(bt8),
        .JUMP(1'b0), .JUMP_TARGET(8'h00), .CALL(1'b0), .RET(1'b0), .TRAP(1'b0),
        .PC(pc8), .PC_NEXT_SEQ(pc_next_seq8), .REDIRECT_PENDING(pend8),
        .RAS_EMPTY(empty8), .RAS_UNDERFLOW(uf8), .RAS_OVERFLOW(of8)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_pc;
    bit          m_pv;
    int          m_pp;
    logic [31:0] m_pt;
    bit          m_pcall, m_pret;
    logic [31:0] m_ras[$];
    bit          m_of, m_uf;
    int          p;
    logic [31:0] t;
    bit          c, r;

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h40; m_pv = 0; m_pp = 0; m_pt = 0; m_pcall = 0; m_pret = 0;
            m_ras.delete(); m_of = 0; m_uf = 0;
        end else begin
            // Priority rank: trap 4, return 3, jump 2, branch 1, sequential 0.
            p = 0; t = m_pc + 32'd4; c = 0; r = 0;
            if (trap)              begin p = 4; t = 32'h100; end
            else if (ret)          begin p = 3; r = 1; t = (m_ras.size() > 0) ? m_ras[$] : m_pc + 32'd4; end
            else if (jump)         begin p = 2; t = jump_target; c = call; end
            else if (branch_taken) begin p = 1; t = branch_target; end
            t = t & 32'hFFFF_FFFC;
            if (busywait || i_busywait) begin
                if (p > 0 && (!m_pv || p > m_pp)) begin
                    m_pv = 1; m_pp = p; m_pt = t; m_pcall = c; m_pret = r;
                end
            end else begin
                if (m_pv) begin t = m_pt; c = m_pcall; r = m_pret; m_pv = 0; end
                if (r) begin
                    if (m_ras.size() > 0) void'(m_ras.pop_back());
                    else m_uf = 1;
                end else if (c) begin
                    if (m_ras.size() == 4) begin void'(m_ras.pop_front()); m_of = 1; end
                    m_ras.push_back(m_pc + 32'd4);
                end
                m_pc = t;
            end
        end
    end

    always @(negedge CLK) begin
        if (mdl_on && rst_n) begin
            chk("cyc_pc",       pc, m_pc);
            chk("cyc_next_seq", pc_next_seq, m_pc + 32'd4);
            chk("cyc_pending",  32'(redirect_pending), 32'(m_pv));
            chk("cyc_ras_empty", 32'(ras_empty), 32'(m_ras.size() == 0));
            chk("cyc_overflow", 32'(ras_overflow), 32'(m_of));
            chk("cyc_underflow", 32'(ras_underflow), 32'(m_uf));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        busywait = 0; i_busywait = 0; branch_taken = 0; jump = 0; call = 0; ret = 0; trap = 0;
        branch_target = 0; jump_target = 0;
    endtask

    logic [31:0] exp_ret [5];

    initial begin
        clear_in();
        br8 = 0; bt8 = 8'h00;
        exp_ret[0] = 32'h4004; exp_ret[1] = 32'h3004; exp_ret[2] = 32'h2004;
        exp_ret[3] = 32'h1004; exp_ret[4] = 32'h1008;

        #2 rst_n = 0; rst8_n = 0;
        mdl_on = 1;
        #1 chk("por_pc", pc, 32'h40);
        chk("por_pc8", 32'(pc8), 32'hF8);
        #10 rst_n = 1; rst8_n = 1;

        // Wrap on the 8-bit instance while the main one counts up.
        tick();
        chk("seq_44", pc, 32'h44);
        chk("w8_fc", 32'(pc8), 32'hFC);
        chk("w8_next_wrap", 32'(pc_next_seq8), 32'h00);
        tick();
        chk("w8_wrap", 32'(pc8), 32'h00);
        chk("w8_flags", 32'({pend8, empty8, uf8, of8}), 32'b0100);
        br8 = 1; bt8 = 8'h13;
        tick();
        chk("w8_align", 32'(pc8), 32'h10);
        br8 = 0;

        // Build some state, then reset asynchronously mid-cycle during a stall.
        jump = 1; call = 1; jump_target = 32'h60;
        tick();
        chk("call_60", pc, 32'h60);
        clear_in();
        i_busywait = 1; branch_taken = 1; branch_target = 32'h80;
        tick();
        chk("pre_rst_pend", 32'(redirect_pending), 32'd1);
        #2 rst_n = 0;
        #1 chk("arst_pc", pc, 32'h40);
        chk("arst_pend", 32'(redirect_pending), 32'd0);
        chk("arst_empty", 32'(ras_empty), 32'd1);
        chk("arst_flags", 32'({ras_underflow, ras_overflow}), 32'd0);
        clear_in();
        #3 rst_n = 1;
        tick(); chk("rel_44", pc, 32'h44);
        tick(); chk("rel_48", pc, 32'h48);
        tick(); chk("rel_4c", pc, 32'h4C);

        // Priority.
        jump = 1; jump_target = 32'h10;
        tick(); chk("to_10", pc, 32'h10);
        trap = 1; jump_target = 32'h200; branch_taken = 1; branch_target = 32'h300;
        tick(); chk("prio_trap", pc, 32'h100);
        trap = 0;
        tick(); chk("prio_jump", pc, 32'h200);
        clear_in();

        // Stall capture and upgrade.
        i_busywait = 1; branch_taken = 1; branch_target = 32'h80;
        tick(); chk("stall_hold1", pc, 32'h200); chk("stall_pend1", 32'(redirect_pending), 32'd1);
        jump = 1; jump_target = 32'h90;
        tick(); chk("stall_hold2", pc, 32'h200);
        tick(); chk("stall_hold3", pc, 32'h200); chk("stall_pend3", 32'(redirect_pending), 32'd1);
        i_busywait = 0; jump = 0;
        tick(); chk("release_90", pc, 32'h90); chk("release_pend", 32'(redirect_pending), 32'd0);
        clear_in();
        tick(); chk("after_94", pc, 32'h94);

        // Call under stall, then return.
        jump = 1; jump_target = 32'h20;
        tick(); chk("to_20", pc, 32'h20);
        busywait = 1; call = 1; jump_target = 32'h400;
        tick(); tick();
        busywait = 0;
        tick(); chk("call_400", pc, 32'h400); chk("call_nonempty", 32'(ras_empty), 32'd0);
        clear_in();
        tick(); chk("seq_404", pc, 32'h404);
        ret = 1;
        tick(); chk("ret_24", pc, 32'h24); chk("single_push", 32'(ras_empty), 32'd1);
        clear_in();

        // Overflow then underflow.
        for (int k = 1; k <= 5; k++) begin
            if (k == 5) chk("of_before", 32'(ras_overflow), 32'd0);
            jump = 1; call = 1; jump_target = 32'(k) << 12;
            tick(); chk("call_k", pc, 32'(k) << 12);
        end
        chk("of_after", 32'(ras_overflow), 32'd1);
        clear_in();
        ret = 1;
        for (int k = 0; k < 5; k++) begin
            if (k == 4) chk("uf_before", 32'(ras_underflow), 32'd0);
            tick(); chk("ret_k", pc, exp_ret[k]);
        end
        chk("uf_after", 32'(ras_underflow), 32'd1);
        clear_in();

        // Randomized traffic, checked each cycle by the model.
        for (int n = 0; n < 3000; n++) begin
            busywait      = ($urandom_range(0, 99) < 20);
            i_busywait    = ($urandom_range(0, 99) < 20);
            trap          = ($urandom_range(0, 99) < 3);
            ret           = ($urandom_range(0, 99) < 12);
            jump          = ($urandom_range(0, 99) < 18);
            call          = ($urandom_range(0, 99) < 50);
            branch_taken  = ($urandom_range(0, 99) < 20);
            jump_target   = $urandom;
            branch_target = $urandom;
            tick();
        end
        clear_in();
        tick();
        chk("sticky_of", 32'(ras_overflow), 32'd1);
        chk("sticky_uf", 32'(ras_underflow), 32'd1);

        @(negedge CLK);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
